// File: rtl/ldpc_pkg.sv
// Shared constants, counter widths and FSM encoding for the LDPC burst feeder.
package ldpc_pkg;
    localparam int CW_LEN       = 9216;
    localparam int CW_PER_FRAME = 15;
    localparam int RD_LAT       = 3;

    localparam int CNT_W   = 14;
    localparam int CW_W    = 4;
    localparam int DRAIN_W = 3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_REQ   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_FIN   = 4'b1000
    } state_t;
endpackage

// File: rtl/ldpc_rcv_framer.sv
// Registers returned samples toward the decoder with sop/eop/index framing.
// One cycle latency from bidin_ena_out to ldc_dv; no backpressure (decoder space is reserved up front).
module ldpc_rcv_framer #(
    parameter int WID    = 6,
    parameter int CW_LEN = ldpc_pkg::CW_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [WID-1:0]            din,
    input  logic [ldpc_pkg::CW_W-1:0] cw_idx,
    output logic                      dv,
    output logic [WID-1:0]            dout,
    output logic                      sop,
    output logic                      eop,
    output logic [ldpc_pkg::CW_W-1:0] idx,
    output logic                      cw_full,
    output logic                      ovf
);
    import ldpc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW_LEN);

    logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;
    logic             dv_q, dv_d, sop_q, sop_d, eop_q, eop_d;
    logic [WID-1:0]   dout_q, dout_d;
    logic [CW_W-1:0]  idx_q, idx_d;

    // rcv_cnt parks at CW_LEN for exactly the eop cycle so the FSM can see completion,
    // then wraps; a sample arriving during that cycle is an overflow.
    assign cw_full = (rcv_cnt_q == CNT_FULL);
    assign ovf     = ena && cw_full;

    always_comb begin
        rcv_cnt_d = rcv_cnt_q;
        if (cw_full)
            rcv_cnt_d = '0;
        else if (ena)
            rcv_cnt_d = rcv_cnt_q + 1'b1;
        dv_d   = ena;
        sop_d  = ena && (rcv_cnt_q == '0);
        eop_d  = ena && (rcv_cnt_q == CNT_LAST);
        dout_d = ena ? din : dout_q;
        idx_d  = ena ? cw_idx : idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_cnt_q <= '0;
            dv_q      <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            dout_q    <= '0;
            idx_q     <= '0;
        end else begin
            rcv_cnt_q <= rcv_cnt_d;
            dv_q      <= dv_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            dout_q    <= dout_d;
            idx_q     <= idx_d;
        end
    end

    assign dv   = dv_q;
    assign dout = dout_q;
    assign sop  = sop_q;
    assign eop  = eop_q;
    assign idx  = idx_q;
endmodule

// File: rtl/ldpc_feeder.sv
// Fetches 15 codewords per frame from the deinterleaver as one read burst each and frames them for the decoder.
// ldpc_req starts one edge after bidin_full & dec_rdy in IDLE; samples reach the decoder RD_LAT+1 cycles after request; dec_rdy only gates burst start.
module ldpc_feeder #(
    parameter int WID          = 6,
    parameter int CW_LEN       = ldpc_pkg::CW_LEN,
    parameter int CW_PER_FRAME = ldpc_pkg::CW_PER_FRAME,
    parameter int RD_LAT       = ldpc_pkg::RD_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bidin_full,
    input  logic                      bidin_ena_out,
    input  logic [WID-1:0]            bidin_dout,
    input  logic                      dec_rdy,
    output logic                      ldpc_req,
    output logic                      ldpc_fin,
    output logic                      ldc_dv,
    output logic [WID-1:0]            ldc_din,
    output logic                      ldc_sop,
    output logic                      ldc_eop,
    output logic [ldpc_pkg::CW_W-1:0] ldc_cw_idx,
    output logic                      frame_done,
    output logic                      err_flag
);
    import ldpc_pkg::*;

    localparam logic [CNT_W-1:0]   REQ_LAST  = CNT_W'(CW_LEN - 1);
    localparam logic [CW_W-1:0]    CW_LAST   = CW_W'(CW_PER_FRAME - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(RD_LAT + 2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
    logic [CW_W-1:0]    cw_cnt_q, cw_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               ldpc_req_q, ldpc_req_d, ldpc_fin_q, ldpc_fin_d;
    logic               frame_done_q, frame_done_d, err_flag_q, err_flag_d;
    logic               cw_full, rcv_ovf;

    ldpc_rcv_framer #(.WID(WID), .CW_LEN(CW_LEN)) u_framer (
        .clk     (clk),
        .rst     (rst),
        .ena     (bidin_ena_out),
        .din     (bidin_dout),
        .cw_idx  (cw_cnt_q),
        .dv      (ldc_dv),
        .dout    (ldc_din),
        .sop     (ldc_sop),
        .eop     (ldc_eop),
        .idx     (ldc_cw_idx),
        .cw_full (cw_full),
        .ovf     (rcv_ovf)
    );

    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        cw_cnt_d     = cw_cnt_q;
        drain_cnt_d  = '0;
        ldpc_req_d   = 1'b0;
        ldpc_fin_d   = 1'b0;
        frame_done_d = 1'b0;
        err_flag_d   = err_flag_q | rcv_ovf;
        case (state_q)
            S_IDLE: begin
                if (bidin_ena_out)
                    err_flag_d = 1'b1;
                if (bidin_full && dec_rdy) begin
                    state_d    = S_REQ;
                    req_cnt_d  = '0;
                    ldpc_req_d = 1'b1;
                end
            end
            S_REQ: begin
                if (req_cnt_q == REQ_LAST) begin
                    state_d   = S_DRAIN;
                    req_cnt_d = '0;
                end else begin
                    req_cnt_d  = req_cnt_q + 1'b1;
                    ldpc_req_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // Saturate so a stuck return path keeps flagging without wrapping.
                drain_cnt_d = (drain_cnt_q == DRAIN_MAX) ? DRAIN_MAX : drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_MAX)
                    err_flag_d = 1'b1;
                if (cw_full) begin
                    state_d      = S_FIN;
                    ldpc_fin_d   = 1'b1;
                    frame_done_d = (cw_cnt_q == CW_LAST);
                end
            end
            S_FIN: begin
                if (bidin_ena_out)
                    err_flag_d = 1'b1;
                cw_cnt_d = (cw_cnt_q == CW_LAST) ? '0 : cw_cnt_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_cnt_q    <= '0;
            cw_cnt_q     <= '0;
            drain_cnt_q  <= '0;
            ldpc_req_q   <= 1'b0;
            ldpc_fin_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            cw_cnt_q     <= cw_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            ldpc_req_q   <= ldpc_req_d;
            ldpc_fin_q   <= ldpc_fin_d;
            frame_done_q <= frame_done_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign ldpc_req   = ldpc_req_q;
    assign ldpc_fin   = ldpc_fin_q;
    assign frame_done = frame_done_q;
    assign err_flag   = err_flag_q;
endmodule

// File: tb/tb_ldpc_feeder.sv
// Directed bench: full-size feeder for burst/reset/error checks, short-codeword feeder for frame wrap.
module tb_ldpc_feeder;
    localparam int CW  = 9216;
    localparam int SCW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, bidin_full = 1'b0, bidin_ena_out = 1'b0, dec_rdy = 1'b0, inject = 1'b0;
    logic [5:0] bidin_dout = '0;
    logic       ldpc_req, ldpc_fin, ldc_dv, ldc_sop, ldc_eop, frame_done, err_flag;
    logic [5:0] ldc_din;
    logic [3:0] ldc_cw_idx;

    logic       s_full = 1'b0, s_ena = 1'b0, s_rdy = 1'b0;
    logic [5:0] s_dout = '0;
    logic       s_req, s_fin, s_dv, s_sop, s_eop, s_fd, s_err;
    logic [5:0] s_din;
    logic [3:0] s_idx;

    ldpc_feeder dut (
        .clk(clk), .rst(rst), .bidin_full(bidin_full), .bidin_ena_out(bidin_ena_out),
        .bidin_dout(bidin_dout), .dec_rdy(dec_rdy), .ldpc_req(ldpc_req), .ldpc_fin(ldpc_fin),
        .ldc_dv(ldc_dv), .ldc_din(ldc_din), .ldc_sop(ldc_sop), .ldc_eop(ldc_eop),
        .ldc_cw_idx(ldc_cw_idx), .frame_done(frame_done), .err_flag(err_flag)
    );

    ldpc_feeder #(.CW_LEN(SCW)) dut_s (
        .clk(clk), .rst(rst), .bidin_full(s_full), .bidin_ena_out(s_ena),
        .bidin_dout(s_dout), .dec_rdy(s_rdy), .ldpc_req(s_req), .ldpc_fin(s_fin),
        .ldc_dv(s_dv), .ldc_din(s_din), .ldc_sop(s_sop), .ldc_eop(s_eop),
        .ldc_cw_idx(s_idx), .frame_done(s_fd), .err_flag(s_err)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full-size deinterleaver model (RD_LAT=3) and monitor.
    int cyc = 0, mdl_n = 0, samp = 0, exp_cw = 0, fin_n = 0, fd_n = 0;
    int req_n = 0, dv_n = 0, sop_n = 0, eop_n = 0, bad_n = 0;
    int rise_cyc = 0, fin_cyc = 0, eop_cyc = 0, dv_first = 0, first_idx = 0;
    int snap_req, snap_dv, snap_sop, snap_eop, snap_bad, snap_gap, snap_lat, snap_idx, snap_fd;
    logic [2:0] pipe = '0;
    logic prev_req = 1'b0;
    logic [5:0] expq[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            pipe = '0; expq.delete(); bidin_ena_out = 1'b0; prev_req = 1'b0;
            samp = 0; exp_cw = 0; req_n = 0; dv_n = 0; sop_n = 0; eop_n = 0; bad_n = 0;
        end else begin
            bidin_ena_out = pipe[2] | inject;
            if (bidin_ena_out) begin
                bidin_dout = 6'(mdl_n * 7 + 3);
                expq.push_back(bidin_dout);
                mdl_n++;
            end
            pipe = {pipe[1:0], ldpc_req};
            if (ldpc_req) begin
                req_n++;
                if (!prev_req) rise_cyc = cyc;
            end
            prev_req = ldpc_req;
            if (ldc_dv) begin
                if (dv_n == 0) begin dv_first = cyc; first_idx = int'(ldc_cw_idx); end
                dv_n++;
                if (expq.size() == 0) bad_n++;
                else if (ldc_din != expq.pop_front()) bad_n++;
                if (ldc_sop != (samp == 0)) bad_n++;
                if (ldc_eop != (samp == CW - 1)) bad_n++;
                if (int'(ldc_cw_idx) != exp_cw) bad_n++;
                if (ldc_sop) sop_n++;
                if (ldc_eop) begin eop_n++; eop_cyc = cyc; end
                samp = (samp == CW - 1) ? 0 : samp + 1;
            end
            if (ldpc_fin) begin
                snap_req = req_n; snap_dv = dv_n; snap_sop = sop_n; snap_eop = eop_n; snap_bad = bad_n;
                snap_gap = cyc - eop_cyc; snap_lat = dv_first - rise_cyc; snap_idx = first_idx;
                snap_fd = int'(frame_done);
                fin_cyc = cyc; fin_n++;
                exp_cw = (exp_cw == 14) ? 0 : exp_cw + 1;
                req_n = 0; dv_n = 0; sop_n = 0; eop_n = 0; bad_n = 0;
            end
            if (frame_done) fd_n++;
        end
    end

    // Short-codeword model and per-codeword records for the frame wrap test.
    int s_cyc = 0, s_cnt = 0, s_fin_n = 0, s_fd_tot = 0, s_dv_n = 0, s_eop_n = 0, s_bad = 0;
    int s_rise = 0, s_last_fin = 0, s_idx_sop = 0;
    int s_dv_rec[16], s_eop_rec[16], s_idx_rec[16], s_fd_rec[16], s_gap_rec[16];
    logic [2:0] s_pipe = '0;
    logic s_prev = 1'b0;
    logic [5:0] s_q[$];

    initial forever begin
        @(negedge clk);
        s_cyc++;
        if (rst) begin
            s_pipe = '0; s_ena = 1'b0; s_q.delete(); s_prev = 1'b0;
        end else begin
            s_ena = s_pipe[2];
            if (s_ena) begin s_dout = 6'(s_cnt * 5 + 1); s_q.push_back(s_dout); s_cnt++; end
            s_pipe = {s_pipe[1:0], s_req};
            if (s_req && !s_prev) s_rise = s_cyc;
            s_prev = s_req;
            if (s_dv) begin
                s_dv_n++;
                if (s_eop) s_eop_n++;
                if (s_sop) s_idx_sop = int'(s_idx);
                if (s_q.size() == 0) s_bad++;
                else if (s_din != s_q.pop_front()) s_bad++;
            end
            if (s_fin && s_fin_n < 16) begin
                s_dv_rec[s_fin_n] = s_dv_n; s_eop_rec[s_fin_n] = s_eop_n;
                s_idx_rec[s_fin_n] = s_idx_sop; s_fd_rec[s_fin_n] = int'(s_fd);
                s_gap_rec[s_fin_n] = s_rise - s_last_fin;
                s_last_fin = s_cyc; s_fin_n++; s_dv_n = 0; s_eop_n = 0;
            end
            if (s_fd) s_fd_tot++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(input string tag, input int target);
        for (int i = 0; i < 12000 && fin_n < target; i++) tick();
        chk(tag, 32'(fin_n >= target), 1);
    endtask

    task automatic wait_req(input string tag, input int target);
        for (int i = 0; i < 12000 && req_n < target; i++) tick();
        chk(tag, 32'(req_n >= target), 1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {15'd0, ldpc_req, ldpc_fin, ldc_dv, ldc_sop, ldc_eop, frame_done, err_flag,
                  ldc_cw_idx, ldc_din}, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_outs_zero("rst_outs");
        rst = 1'b0;
        tick();

        // Frame wrap on short codewords: 16 back-to-back bursts.
        s_full = 1'b1; s_rdy = 1'b1;
        for (int i = 0; i < 2000 && s_fin_n < 16; i++) tick();
        s_full = 1'b0;
        chk("s_16_fins", 32'(s_fin_n), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("s_dv_%0d", k), 32'(s_dv_rec[k]), SCW);
            chk($sformatf("s_eop_%0d", k), 32'(s_eop_rec[k]), 1);
            chk($sformatf("s_idx_%0d", k), 32'(s_idx_rec[k]), 32'(k % 15));
            chk($sformatf("s_fd_%0d", k), 32'(s_fd_rec[k]), 32'(k == 14));
            if (k > 0) chk($sformatf("s_gap_%0d", k), 32'(s_gap_rec[k]), 2);
        end
        chk("s_fd_total", 32'(s_fd_tot), 1);
        chk("s_data_bad", 32'(s_bad), 0);
        chk("s_err", 32'(s_err), 0);

        // Full-size burst.
        bidin_full = 1'b1; dec_rdy = 1'b1;
        wait_fin("cw0_done", 1);
        dec_rdy = 1'b0;
        chk("cw0_req", 32'(snap_req), CW);
        chk("cw0_dv", 32'(snap_dv), CW);
        chk("cw0_sop", 32'(snap_sop), 1);
        chk("cw0_eop", 32'(snap_eop), 1);
        chk("cw0_eop_fin", 32'(snap_gap), 1);
        chk("cw0_lat", 32'(snap_lat), 4);
        chk("cw0_bad", 32'(snap_bad), 0);
        chk("cw0_idx", 32'(snap_idx), 0);
        chk("cw0_fd", 32'(snap_fd), 0);

        // dec_rdy low blocks the burst even with bidin_full high.
        repeat (100) tick();
        chk("rdy_hold_req", 32'(req_n), 0);
        chk("rdy_hold_line", 32'(ldpc_req), 0);
        dec_rdy = 1'b1;
        tick();
        chk("rdy_start", 32'(ldpc_req), 1);

        // dec_rdy drop mid-burst is ignored.
        wait_req("req_5000", 5000);
        dec_rdy = 1'b0;
        wait_fin("cw1_done", 2);
        chk("cw1_req", 32'(snap_req), CW);
        chk("cw1_dv", 32'(snap_dv), CW);
        chk("cw1_bad", 32'(snap_bad), 0);
        chk("cw1_idx", 32'(snap_idx), 1);
        chk("cw1_err", 32'(err_flag), 0);
        repeat (10) tick();
        chk("rdy_low_idle", 32'(ldpc_req), 0);

        // Reset mid-burst, then a fresh burst.
        dec_rdy = 1'b1;
        wait_req("req_4000", 4000);
        rst = 1'b1;
        tick();
        chk_outs_zero("midrst_outs");
        tick();
        rst = 1'b0;
        wait_fin("cw2_done", 3);
        bidin_full = 1'b0;
        chk("post_rst_idx", 32'(snap_idx), 0);
        chk("post_rst_sop", 32'(snap_sop), 1);
        chk("post_rst_req", 32'(snap_req), CW);
        chk("post_rst_bad", 32'(snap_bad), 0);
        chk("post_rst_lat", 32'(snap_lat), 4);
        chk("post_rst_err", 32'(err_flag), 0);

        // Spurious strobe in IDLE sets the sticky error.
        repeat (5) tick();
        chk("err_before", 32'(err_flag), 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("err_set", 32'(err_flag), 1);
        repeat (20) tick();
        chk("err_sticky", 32'(err_flag), 1);
        chk("frame_done_none", 32'(fd_n), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
